rca_settle_checker: RTL and testbench

- Sequencing stage wrapped around the 64-bit ripple-carry adder.
- Accepts operand triples over a valid/ready handshake and drives them onto the adder inputs.
- Holds those inputs stable for a programmable number of clock cycles so the ripple can settle, then captures S/C_Out.
- Compares the captured result against an internal behavioural sum and presents result plus mismatch flag downstream. It replaces free-running testbench stimulus with a deterministic, clocked measurement harness.

---
 rtl/rca_settle_checker.sv | 174 +++++++++++++++++
 tb/tb_rca_settle_checker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_settle_checker.sv
// rca_settle_checker: clocked measurement harness around a ripple-carry adder.
// Each accepted operand triple is driven onto the adder, held for SETTLE_CYCLES
// clocks so the carry chain settles, and then the adder result is captured and
// compared with a behavioural reference sum. A saturating counter tracks mismatches.
// Optional feature macro: RCA_FIRST_ERR_CAPTURE_EN adds registers that record
// the operands of the first mismatching capture after reset.

module rca_settle_checker #(
  parameter int WIDTH         = 64,
  parameter int SETTLE_CYCLES = 5,
  parameter int ERR_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_s,
  output logic             res_cout,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count
`ifdef RCA_FIRST_ERR_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic             first_err_cin,
  output logic             first_err_vld
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // The counter is loaded with SETTLE_CYCLES-1 so capture lands exactly
  // SETTLE_CYCLES edges after the accept edge.
  localparam logic [7:0]       CNT_INIT = 8'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  state_t           state_r;
  state_t           state_next_s;
  logic [7:0]       cnt_r;
  logic [WIDTH-1:0] exp_s_r;
  logic             exp_cout_r;
  logic             accept_s;
  logic             capture_s;
  logic             release_s;
  logic             mismatch_s;

  // Behavioural reference: full WIDTH+1 bit sum so the carry is never truncated.
  function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             cin);
    ref_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  endfunction

  assign in_ready   = (state_r == IDLE);
  assign mismatch_s = ({add_cout, add_s} != {exp_cout_r, exp_s_r});

  // Next-state and handshake event decode.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    release_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          accept_s     = 1'b1;
          state_next_s = SETTLE;
        end else begin
          state_next_s = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_r == 8'd0) begin
          capture_s    = 1'b1;
          state_next_s = HOLD;
        end else begin
          state_next_s = SETTLE;
        end
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          release_s    = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand launch, settle countdown, result capture and mismatch counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_a      <= {WIDTH{1'b0}};
      add_b      <= {WIDTH{1'b0}};
      add_cin    <= 1'b0;
      cnt_r      <= 8'd0;
      exp_s_r    <= {WIDTH{1'b0}};
      exp_cout_r <= 1'b0;
      res_s      <= {WIDTH{1'b0}};
      res_cout   <= 1'b0;
      mismatch   <= 1'b0;
      out_valid  <= 1'b0;
      err_count  <= {ERR_W{1'b0}};
    end else begin
      if (accept_s) begin
        add_a                 <= in_a;
        add_b                 <= in_b;
        add_cin               <= in_cin;
        cnt_r                 <= CNT_INIT;
        {exp_cout_r, exp_s_r} <= ref_sum(in_a, in_b, in_cin);
      end else if ((state_r == SETTLE) && (cnt_r != 8'd0)) begin
        cnt_r <= cnt_r - 8'd1;
      end
      if (capture_s) begin
        res_s     <= add_s;
        res_cout  <= add_cout;
        mismatch  <= mismatch_s;
        out_valid <= 1'b1;
        if (mismatch_s && (err_count != ERR_MAX)) begin
          err_count <= err_count + ERR_ONE;
        end
      end
      if (release_s) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RCA_FIRST_ERR_CAPTURE_EN
  // Record the operands of the first mismatching capture; later ones are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_err_a   <= {WIDTH{1'b0}};
      first_err_b   <= {WIDTH{1'b0}};
      first_err_cin <= 1'b0;
      first_err_vld <= 1'b0;
    end else if (capture_s && mismatch_s && !first_err_vld) begin
      first_err_a   <= add_a;
      first_err_b   <= add_b;
      first_err_cin <= add_cin;
      first_err_vld <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rca_settle_checker.sv
// Self-checking bench for rca_settle_checker.
// Three instances: u0 (defaults, switchable adder model), u1 (SETTLE_CYCLES=10,
// adder delayed by 8 cycles) and u2 (ERR_W=2, adder sum forced to zero).
// Expected results are queued when a transaction is driven and popped when
// the instance presents its result.

module tb_rca_settle_checker;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  in_valid;
  logic [2:0]  out_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_cin;
  logic [1:0]  mode;
  int          cur;

  logic        rdy0, ov0, rc0, mm0, ac0, c0;
  logic [63:0] aa0, ab0, rs0, s0;
  logic [15:0] ec0;
  logic        rdy1, ov1, rc1, mm1, ac1, c1;
  logic [63:0] aa1, ab1, rs1, s1;
  logic [15:0] ec1;
  logic        rdy2, ov2, rc2, mm2, ac2, c2;
  logic [63:0] aa2, ab2, rs2, s2;
  logic [1:0]  ec2;
`ifdef RCA_FIRST_ERR_CAPTURE_EN
  logic [63:0] fa0, fb0, fa1, fb1, fa2, fb2;
  logic        fc0, fv0, fc1, fv1, fc2, fv2;
`endif

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        m;
    logic [15:0] e;
  } exp_t;
  exp_t sb[$];

  function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic c);
    return {1'b0, a} + {1'b0, b} + {64'd0, c};
  endfunction

  // Adder models: u0 ideal / 8-cycle delayed / zero, u1 delayed, u2 zero.
  logic [64:0] pipe0 [8];
  logic [64:0] pipe1 [8];
  always @(posedge clk) begin
    pipe0[0] <= ref_add(aa0, ab0, ac0);
    pipe1[0] <= ref_add(aa1, ab1, ac1);
    for (int i = 1; i < 8; i++) begin
      pipe0[i] <= pipe0[i-1];
      pipe1[i] <= pipe1[i-1];
    end
  end

  always_comb begin
    case (mode)
      2'd0:    {c0, s0} = ref_add(aa0, ab0, ac0);
      2'd1:    {c0, s0} = pipe0[7];
      default: {c0, s0} = 65'd0;
    endcase
  end
  assign {c1, s1} = pipe1[7];
  assign {c2, s2} = 65'd0;

  rca_settle_checker u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(rdy0),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(aa0), .add_b(ab0), .add_cin(ac0), .add_s(s0), .add_cout(c0),
    .out_valid(ov0), .out_ready(out_ready[0]), .res_s(rs0), .res_cout(rc0),
    .mismatch(mm0), .err_count(ec0)
`ifdef RCA_FIRST_ERR_CAPTURE_EN
    , .first_err_a(fa0), .first_err_b(fb0), .first_err_cin(fc0), .first_err_vld(fv0)
`endif
  );

  rca_settle_checker #(.SETTLE_CYCLES(10)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(aa1), .add_b(ab1), .add_cin(ac1), .add_s(s1), .add_cout(c1),
    .out_valid(ov1), .out_ready(out_ready[1]), .res_s(rs1), .res_cout(rc1),
    .mismatch(mm1), .err_count(ec1)
`ifdef RCA_FIRST_ERR_CAPTURE_EN
    , .first_err_a(fa1), .first_err_b(fb1), .first_err_cin(fc1), .first_err_vld(fv1)
`endif
  );

  rca_settle_checker #(.ERR_W(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(rdy2),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(aa2), .add_b(ab2), .add_cin(ac2), .add_s(s2), .add_cout(c2),
    .out_valid(ov2), .out_ready(out_ready[2]), .res_s(rs2), .res_cout(rc2),
    .mismatch(mm2), .err_count(ec2)
`ifdef RCA_FIRST_ERR_CAPTURE_EN
    , .first_err_a(fa2), .first_err_b(fb2), .first_err_cin(fc2), .first_err_vld(fv2)
`endif
  );

  // View of the instance selected by cur.
  logic        v_rdy, v_ov, v_rc, v_mm, v_ac;
  logic [63:0] v_aa, v_ab, v_rs;
  logic [15:0] v_ec;
  always_comb begin
    case (cur)
      0: begin
        v_rdy = rdy0; v_ov = ov0; v_rc = rc0; v_mm = mm0; v_ac = ac0;
        v_aa = aa0; v_ab = ab0; v_rs = rs0; v_ec = ec0;
      end
      1: begin
        v_rdy = rdy1; v_ov = ov1; v_rc = rc1; v_mm = mm1; v_ac = ac1;
        v_aa = aa1; v_ab = ab1; v_rs = rs1; v_ec = ec1;
      end
      default: begin
        v_rdy = rdy2; v_ov = ov2; v_rc = rc2; v_mm = mm2; v_ac = ac2;
        v_aa = aa2; v_ab = ab2; v_rs = rs2; v_ec = {14'd0, ec2};
      end
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One transaction on instance sel; hold>0 keeps out_ready low that many cycles.
  task automatic txn(input int sel, input logic [63:0] a, input logic [63:0] b,
                     input logic cin, input logic [63:0] es, input logic ec,
                     input logic em, input logic [15:0] ee, input int hold);
    int   n;
    int   settle;
    exp_t e;
    cur    = sel;
    settle = (sel == 1) ? 10 : 5;
    n = 0;
    @(negedge clk);
    while (!v_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", v_rdy, 1'b1);
    in_a = a; in_b = b; in_cin = cin;
    in_valid[sel] = 1'b1;
    e.s = es; e.c = ec; e.m = em; e.e = ee;
    sb.push_back(e);
    @(negedge clk);
    in_valid[sel] = 1'b0;
    in_a = 64'hDEAD_BEEF_0000_0001;
    check("in_ready_busy", v_rdy, 1'b0);
    n = 0;
    while (!v_ov && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'(settle));
    check("add_a_held", v_aa, a);
    check("add_b_held", v_ab, b);
    e = sb.pop_front();
    check("res_s", v_rs, e.s);
    check("res_cout", v_rc, e.c);
    check("mismatch", v_mm, e.m);
    check("err_count", v_ec, e.e);
    for (int i = 0; i < hold; i++) begin
      in_valid[sel] = 1'b1;
      in_a = {$urandom, $urandom};
      @(negedge clk);
      check("hold_valid", v_ov, 1'b1);
      check("hold_res_s", v_rs, e.s);
      check("hold_ready", v_rdy, 1'b0);
      check("hold_add_a", v_aa, a);
    end
    in_valid[sel]  = 1'b0;
    out_ready[sel] = 1'b1;
    @(negedge clk);
    out_ready[sel] = 1'b0;
    check("release_valid", v_ov, 1'b0);
    check("release_ready", v_rdy, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 3'd0; out_ready = 3'd0;
    in_a = 64'd0; in_b = 64'd0; in_cin = 1'b0; mode = 2'd0; cur = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", v_rdy, 1'b1);
    check("rst_valid", v_ov, 1'b0);
    check("rst_add_a", v_aa, 64'd0);
    check("rst_res_s", v_rs, 64'd0);
    check("rst_mismatch", v_mm, 1'b0);
    check("rst_err", v_ec, 16'd0);

    // Ideal adder on u0.
    txn(0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, 1'b1, 1'b0, 16'd0, 0);
    txn(0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h1, 1'b1, 1'b0, 16'd0, 0);
    txn(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0,
        64'hAAAA_AAAA_AAAA_AAA9, 1'b1, 1'b0, 16'd0, 0);
    txn(0, 64'hFF, 64'hFF01, 1'b1, 64'h10001, 1'b0, 1'b0, 16'd0, 0);
    txn(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
        64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 16'd0, 0);
    // Back-pressure: out_ready low for 10 cycles while in_valid is high.
    txn(0, 64'd123, 64'd456, 1'b0, 64'd579, 1'b0, 1'b0, 16'd0, 10);

    // Reset while SETTLE counter is at 2.
    cur = 0;
    in_a = 64'd7; in_b = 64'd9; in_cin = 1'b1;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", v_rdy, 1'b1);
    check("midrst_valid", v_ov, 1'b0);
    check("midrst_add_a", v_aa, 64'd0);
    check("midrst_add_b", v_ab, 64'd0);
    check("midrst_add_cin", v_ac, 1'b0);
    check("midrst_err", v_ec, 16'd0);
`ifdef RCA_FIRST_ERR_CAPTURE_EN
    check("midrst_first_vld", fv0, 1'b0);
`endif
    repeat (12) @(negedge clk);
    check("midrst_no_output", v_ov, 1'b0);

    // Adder delayed by 8 cycles: SETTLE_CYCLES=5 captures the stale sum of 0.
    mode = 2'd1;
    txn(0, 64'd5, 64'd6, 1'b0, 64'd0, 1'b0, 1'b1, 16'd1, 0);
`ifdef RCA_FIRST_ERR_CAPTURE_EN
    check("first_vld", fv0, 1'b1);
    check("first_a", fa0, 64'd5);
    check("first_b", fb0, 64'd6);
`endif
    // Same delayed model with SETTLE_CYCLES=10 settles correctly.
    txn(1, 64'd5, 64'd6, 1'b0, 64'd11, 1'b0, 1'b0, 16'd0, 0);

    // ERR_W=2 saturation with add_s forced to zero.
    txn(2, 64'd3, 64'd4, 1'b0, 64'd0, 1'b0, 1'b1, 16'd1, 0);
    txn(2, 64'd3, 64'd4, 1'b0, 64'd0, 1'b0, 1'b1, 16'd2, 0);
    txn(2, 64'd3, 64'd4, 1'b0, 64'd0, 1'b0, 1'b1, 16'd3, 0);
    txn(2, 64'd3, 64'd4, 1'b0, 64'd0, 1'b0, 1'b1, 16'd3, 0);
    txn(2, 64'd3, 64'd4, 1'b0, 64'd0, 1'b0, 1'b1, 16'd3, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
